// File: rtl/arbiter_rr_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr_pipe_if
// Description : Bundle of the N-input valid/ready/last streams and the single
//               registered output stream of arbiter_rr_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface arbiter_rr_pipe_if #(
    parameter int DWIDTH = 8,
    parameter int N      = 2,
    parameter int ID_W   = (N > 1) ? $clog2(N) : 1
);
    // Per-channel request side
    logic              in_valid [N-1:0];
    logic [DWIDTH-1:0] in_data  [N-1:0];
    logic              in_last  [N-1:0];
    logic              in_ready [N-1:0];

    // Shared downstream side
    logic              out_valid;
    logic [DWIDTH-1:0] out_data;
    logic              out_last;
    logic [ID_W-1:0]   out_id;
    logic              out_ready;

    // Environment side: drives requests and downstream ready
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_id
    );

    // Arbiter side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_id
    );
endinterface
`default_nettype wire

// File: rtl/arbiter_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module      : arbiter_rr_pipe
// Description : N-to-1 valid/ready arbiter with round-robin or fixed priority,
//               packet locking on in_last, and a registered output stage that
//               carries the winning channel index.
// Revision    : 1.0 - initial release
// ============================================================================
module arbiter_rr_pipe #(
    parameter int DWIDTH      = 8,
    parameter int N           = 2,
    parameter int ROUND_ROBIN = 1,
    parameter int ID_W        = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    arbiter_rr_pipe_if.slave   bus
);

    localparam logic [ID_W-1:0] c_last_id = ID_W'(N - 1);

    // Arbitration state
    logic [ID_W-1:0]   r_ptr;
    logic              r_locked;
    logic [ID_W-1:0]   r_lock_id;

    // Output register
    logic              r_out_valid;
    logic [DWIDTH-1:0] r_out_data;
    logic              r_out_last;
    logic [ID_W-1:0]   r_out_id;

    // Combinational arbitration results
    logic [N-1:0]      w_grant;
    logic              w_gnt_any;
    logic [ID_W-1:0]   w_gnt_id;
    logic [ID_W-1:0]   w_cand;
    logic [ID_W-1:0]   w_next_ptr;
    logic              w_load_en;
    logic              w_xfer;

    // Output register may take a new beat when empty or being drained this cycle
    assign w_load_en = !r_out_valid || bus.out_ready;

    // Grant selection: locked owner only, otherwise first valid scanning from ptr
    always_comb begin
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        w_cand    = '0;
        if (r_locked) begin
            if (bus.in_valid[r_lock_id]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = r_lock_id;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                w_cand = ID_W'((int'(r_ptr) + k) % N);
                if (!w_gnt_any && bus.in_valid[w_cand]) begin
                    w_gnt_any = 1'b1;
                    w_gnt_id  = w_cand;
                end
            end
        end
        if (w_gnt_any) begin
            w_grant[w_gnt_id] = 1'b1;
        end
    end

    // A transfer happens whenever a grant meets a loadable output register
    assign w_xfer     = w_gnt_any && w_load_en && !rst;
    assign w_next_ptr = (w_gnt_id == c_last_id) ? '0 : w_gnt_id + 1'b1;

    generate
        for (genvar i = 0; i < N; i++) begin : g_ready
            assign bus.in_ready[i] = w_grant[i] && w_load_en && !rst;
        end
    endgenerate

    // Packet lock and round-robin pointer; pointer only moves past a last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_locked  <= 1'b0;
            r_lock_id <= '0;
        end else if (w_xfer) begin
            if (!bus.in_last[w_gnt_id]) begin
                r_locked  <= 1'b1;
                r_lock_id <= w_gnt_id;
            end else begin
                r_locked <= 1'b0;
                if (ROUND_ROBIN != 0) begin
                    r_ptr <= w_next_ptr;
                end
            end
        end
    end

    // Output stage: load on transfer, drop on drain, otherwise hold stable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_id    <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.in_data[w_gnt_id];
            r_out_last  <= bus.in_last[w_gnt_id];
            r_out_id    <= w_gnt_id;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_arbiter_rr_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbiter_rr_pipe
// Description : Self-checking bench for arbiter_rr_pipe; a round-robin and a
//               fixed-priority instance (N=4) are scored every cycle against
//               a behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbiter_rr_pipe;

    localparam int DW = 8;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arbiter_rr_pipe_if #(.DWIDTH(DW), .N(NC)) if_rr ();
    arbiter_rr_pipe_if #(.DWIDTH(DW), .N(NC)) if_fx ();

    arbiter_rr_pipe #(.DWIDTH(DW), .N(NC), .ROUND_ROBIN(1)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (if_rr)
    );

    arbiter_rr_pipe #(.DWIDTH(DW), .N(NC), .ROUND_ROBIN(0)) u_fx (
        .clk (clk),
        .rst (rst),
        .bus (if_fx)
    );

    // Stimulus: index 0 = round-robin instance, 1 = fixed-priority instance
    logic [3:0]    v_valid  [2];
    logic [3:0]    v_last   [2];
    logic [DW-1:0] v_data   [2][NC];
    logic          v_oready [2];
    wire  [3:0]    rdy_rr;
    wire  [3:0]    rdy_fx;

    generate
        for (genvar i = 0; i < NC; i++) begin : g_ch
            assign if_rr.in_valid[i] = v_valid[0][i];
            assign if_rr.in_last[i]  = v_last[0][i];
            assign if_rr.in_data[i]  = v_data[0][i];
            assign if_fx.in_valid[i] = v_valid[1][i];
            assign if_fx.in_last[i]  = v_last[1][i];
            assign if_fx.in_data[i]  = v_data[1][i];
            assign rdy_rr[i]         = if_rr.in_ready[i];
            assign rdy_fx[i]         = if_fx.in_ready[i];
        end
    endgenerate
    assign if_rr.out_ready = v_oready[0];
    assign if_fx.out_ready = v_oready[1];

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: who owns the port, where the scan starts, what is held
    int            m_ptr   [2];
    int            m_owner [2];
    bit            m_ov    [2];
    logic [DW-1:0] m_od    [2];
    bit            m_ol    [2];
    int            m_oid   [2];

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_ptr[s] = 0; m_owner[s] = -1; m_ov[s] = 1'b0;
            m_od[s] = '0; m_ol[s] = 1'b0; m_oid[s] = 0;
        end
    endfunction

    // Winner: the packet owner if it is requesting, else first requester from ptr
    function automatic int pick(logic [3:0] v, int ptr, int owner);
        if (owner >= 0) return (((v >> owner) & 4'd1) != 0) ? owner : -1;
        for (int k = 0; k < NC; k++) begin
            int c;
            c = (ptr + k) % NC;
            if (((v >> c) & 4'd1) != 0) return c;
        end
        return -1;
    endfunction

    // Advance one clock, scoring ready (mid-cycle) and outputs (after the edge)
    task automatic tick_and_score();
        int         g [2];
        bit         x [2];
        logic [3:0] exp_rdy, obs_rdy;
        logic [1:0] gi;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            g[s] = pick(v_valid[s], m_ptr[s], m_owner[s]);
            x[s] = (g[s] >= 0) && (!m_ov[s] || v_oready[s]) && !rst;
            exp_rdy = x[s] ? (4'b0001 << g[s]) : 4'b0000;
            obs_rdy = (s == 0) ? rdy_rr : rdy_fx;
            n_checks++;
            if (obs_rdy !== exp_rdy) begin
                n_errors++;
                $display("FAIL in_ready[inst%0d] t=%0t: got %b want %b", s, $time, obs_rdy, exp_rdy);
            end
        end
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_ptr[s] = 0; m_owner[s] = -1; m_ov[s] = 1'b0;
                m_od[s] = '0; m_ol[s] = 1'b0; m_oid[s] = 0;
            end else if (x[s]) begin
                gi = 2'(g[s]);
                m_ov[s]  = 1'b1;
                m_od[s]  = v_data[s][gi];
                m_ol[s]  = v_last[s][gi];
                m_oid[s] = g[s];
                if (v_last[s][gi]) begin
                    m_owner[s] = -1;
                    if (s == 0) m_ptr[s] = (g[s] + 1) % NC;
                end else begin
                    m_owner[s] = g[s];
                end
            end else if (v_oready[s]) begin
                m_ov[s] = 1'b0;
            end
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            logic          ov, ol;
            logic [DW-1:0] od;
            logic [1:0]    oid;
            ov  = (s == 0) ? if_rr.out_valid : if_fx.out_valid;
            od  = (s == 0) ? if_rr.out_data  : if_fx.out_data;
            ol  = (s == 0) ? if_rr.out_last  : if_fx.out_last;
            oid = (s == 0) ? if_rr.out_id    : if_fx.out_id;
            n_checks++;
            if (ov !== m_ov[s] || od !== m_od[s] || ol !== m_ol[s] || oid !== 2'(m_oid[s])) begin
                n_errors++;
                $display("FAIL out_stage[inst%0d] t=%0t: got v=%b d=%h l=%b id=%0d want v=%b d=%h l=%b id=%0d",
                         s, $time, ov, od, ol, oid, m_ov[s], m_od[s], m_ol[s], m_oid[s]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            v_valid[s] = 4'b1111; v_last[s] = 4'b1111; v_oready[s] = 1'b1;
        end
        repeat (3) begin
            tick_and_score();
            n_checks++;
            if (if_rr.out_valid !== 1'b0 || if_rr.out_data !== 8'h00 || rdy_rr !== 4'b0000) begin
                n_errors++;
                $display("FAIL reset_idle: v=%b d=%h rdy=%b want 0/00/0000", if_rr.out_valid, if_rr.out_data, rdy_rr);
            end
        end
        rst = 1'b0;
        tick_and_score();
        n_checks++;
        if (if_rr.out_valid !== 1'b1 || if_rr.out_id !== 2'd0 || if_rr.out_data !== v_data[0][0]) begin
            n_errors++;
            $display("FAIL reset_first_beat: v=%b id=%0d d=%h want 1/0/%h", if_rr.out_valid, if_rr.out_id, if_rr.out_data, v_data[0][0]);
        end
    endtask

    task automatic test_rr_fairness();
        int exp_id;
        exp_id = 1;
        repeat (8) begin
            tick_and_score();
            n_checks++;
            if (if_rr.out_valid !== 1'b1 || if_rr.out_id !== 2'(exp_id)) begin
                n_errors++;
                $display("FAIL rr_fairness: v=%b id=%0d want 1/%0d", if_rr.out_valid, if_rr.out_id, exp_id);
            end
            exp_id = (exp_id + 1) % NC;
        end
    endtask

    task automatic test_fixed_priority();
        v_valid[1] = 4'b1010;
        repeat (4) begin
            tick_and_score();
            n_checks++;
            if (if_fx.out_valid !== 1'b1 || if_fx.out_id !== 2'd1) begin
                n_errors++;
                $display("FAIL fixed_prio: v=%b id=%0d want 1/1", if_fx.out_valid, if_fx.out_id);
            end
        end
        v_valid[1] = 4'b1000;
        tick_and_score();
        n_checks++;
        if (if_fx.out_valid !== 1'b1 || if_fx.out_id !== 2'd3) begin
            n_errors++;
            $display("FAIL fixed_drop: v=%b id=%0d want 1/3", if_fx.out_valid, if_fx.out_id);
        end
    endtask

    task automatic test_packet_lock();
        logic [1:0] exp_ids [5];
        logic       exp_v   [5];
        logic [3:0] vals    [5];
        logic [3:0] lasts   [5];
        // ch1 alone moves ptr to 2, then ch2 sends 3 beats with a gap, then all request
        vals  = '{4'b0010, 4'b0101, 4'b0101, 4'b0001, 4'b0101};
        lasts = '{4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1111};
        exp_v   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_ids = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
        for (int k = 0; k < 5; k++) begin
            v_valid[0] = vals[k];
            v_last[0]  = lasts[k];
            tick_and_score();
            n_checks++;
            if (if_rr.out_valid !== exp_v[k] || (exp_v[k] && if_rr.out_id !== exp_ids[k])) begin
                n_errors++;
                $display("FAIL pkt_lock step%0d: v=%b id=%0d want %b/%0d", k, if_rr.out_valid, if_rr.out_id, exp_v[k], exp_ids[k]);
            end
        end
        v_valid[0] = 4'b1111;
        tick_and_score();
        n_checks++;
        if (if_rr.out_valid !== 1'b1 || if_rr.out_id !== 2'd3) begin
            n_errors++;
            $display("FAIL pkt_ptr_after: v=%b id=%0d want 1/3", if_rr.out_valid, if_rr.out_id);
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] saved;
        saved = v_data[0][1];
        v_data[0][1] = 8'hA5;
        v_valid[0]   = 4'b0010;
        tick_and_score();
        v_oready[0] = 1'b0;
        v_valid[0]  = 4'b1111;
        repeat (5) begin
            tick_and_score();
            n_checks++;
            if (if_rr.out_valid !== 1'b1 || if_rr.out_data !== 8'hA5 || rdy_rr !== 4'b0000) begin
                n_errors++;
                $display("FAIL backpressure_hold: v=%b d=%h rdy=%b want 1/a5/0000", if_rr.out_valid, if_rr.out_data, rdy_rr);
            end
        end
        v_oready[0] = 1'b1;
        tick_and_score();
        n_checks++;
        if (if_rr.out_valid !== 1'b1 || if_rr.out_id !== 2'd2 || if_rr.out_data !== v_data[0][2]) begin
            n_errors++;
            $display("FAIL backpressure_release: v=%b id=%0d d=%h want 1/2/%h", if_rr.out_valid, if_rr.out_id, if_rr.out_data, v_data[0][2]);
        end
        v_data[0][1] = saved;
    endtask

    task automatic test_mid_packet_reset();
        v_valid[0] = 4'b0010;
        v_last[0]  = 4'b1101;
        tick_and_score();
        v_valid[0] = 4'b0011;
        rst = 1'b1;
        tick_and_score();
        n_checks++;
        if (if_rr.out_valid !== 1'b0 || if_rr.out_data !== 8'h00) begin
            n_errors++;
            $display("FAIL midpkt_reset: v=%b d=%h want 0/00", if_rr.out_valid, if_rr.out_data);
        end
        rst = 1'b0;
        tick_and_score();
        n_checks++;
        if (if_rr.out_valid !== 1'b1 || if_rr.out_id !== 2'd0) begin
            n_errors++;
            $display("FAIL midpkt_after: v=%b id=%0d want 1/0", if_rr.out_valid, if_rr.out_id);
        end
        v_last[0] = 4'b1111;
    endtask

    task automatic test_random();
        repeat (600) begin
            for (int s = 0; s < 2; s++) begin
                v_valid[s]  = 4'($urandom_range(0, 15));
                v_oready[s] = ($urandom_range(0, 3) != 0);
                for (int c = 0; c < NC; c++) begin
                    v_last[s][c] = ($urandom_range(0, 2) != 0);
                    v_data[s][c] = 8'($urandom);
                end
            end
            rst = ($urandom_range(0, 79) == 0);
            tick_and_score();
        end
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        for (int s = 0; s < 2; s++) begin
            v_valid[s] = '0; v_last[s] = '1; v_oready[s] = 1'b1;
            for (int c = 0; c < NC; c++) v_data[s][c] = 8'(16 * (c + 1) + s + 3);
        end
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_packet_lock();
        test_backpressure();
        test_mid_packet_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbiter_rr_pipe.md
# arbiter_rr_pipe

Parametrised N-to-1 arbiter for valid/ready streams. It selects among up to N requesters using fixed or round-robin priority, and can hold a grant across multi-beat packets. The winning beat goes into a registered output stage, and the winner's index is carried alongside the data. It sits where the combinational fixed-priority arbiter is used today, i.e. between engine result/request channels and a shared downstream port, when fairness, packet atomicity or a register cut is required.

## Interface
Parameters:
- DWIDTH, 8, payload width in bits.
- N, 2, number of input channels; legal range 1..64.
- ROUND_ROBIN, 1, priority mode: 1 = round-robin, 0 = fixed (index 0 highest).
- ID_W, (N>1 ? $clog2(N) : 1), width of the source index; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1 x [N-1:0]  per-channel valid (unpacked array).
- in_data  in  DWIDTH x [N-1:0]  per-channel payload (unpacked array).
- in_last  in  1 x [N-1:0]  per-channel end-of-packet marker; tie to 1 for single-beat traffic.
- in_ready  out  1 x [N-1:0]  per-channel ready (unpacked array).
- out_valid  out  1  output register holds a beat.
- out_data  out  DWIDTH  registered payload.
- out_last  out  1  registered in_last of that beat.
- out_id  out  ID_W  index of the channel that supplied the beat.
- out_ready  in  1  downstream accepts.

## Operation
- Output stage: a single register holding {data, last, id}. It can load when `load_en = !out_valid || out_ready`.
- Grant is combinational from in_valid, ptr, locked and lock_id. It is one-hot or zero.
  - `in_ready[i] = grant[i] & load_en`.
  - A transfer on channel i is `in_valid[i] & in_ready[i]`.
  - At most one channel transfers per cycle.
- Unlocked, ROUND_ROBIN=1: scan indices ptr, ptr+1, …, wrapping N-1 → 0. The first index with in_valid=1 is granted.
- Unlocked, ROUND_ROBIN=0: the lowest index with in_valid=1 is granted. ptr stays 0.
- Locked: only lock_id is granted, regardless of other valids. If in_valid[lock_id]=0, no grant is made (a bubble).
- On a transfer from channel i:
  - If in_last[i]=0: set locked=1 and lock_id=i.
  - If in_last[i]=1: clear locked. In round-robin mode, set ptr = (i+1) mod N.
  - ptr never advances on a non-last beat.
- Output register update, in priority order:
  - If a transfer occurs: load in_data[i], in_last[i], i, and set out_valid=1.
  - Else if out_ready=1: clear out_valid.
  - Else: hold.
- Contents are held stable while `out_valid & !out_ready`. This is AXI-stream-style compliance.
- in_valid must not depend on in_ready. in_ready may depend on out_ready (combinational path).
- N=1: grant = in_valid[0], ptr and lock are unused, out_id=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_id=0, ptr=0, locked=0, lock_id=0.
  - in_ready is all-zero while rst=1.
  - rst asserted mid-packet drops the lock and any held output beat in the same edge.
- Latency: an input transfer in cycle t gives out_valid=1 with that beat from cycle t+1.
- Throughput: 1 beat/cycle when out_ready stays high, including back-to-back beats from different channels.
- Backpressure: `out_valid=1 & out_ready=0` forces all in_ready=0. A simultaneous out_ready=1 with a new transfer replaces the beat in the same edge, with no bubble.
- Wrap-around: ptr=N-1 with a last-beat transfer from N-1 gives ptr=0.
- A channel deasserting in_valid while its grant was pending (no transfer) does not move ptr.

## Test plan
- Reset/idle: hold rst=1 for 3 cycles with all in_valid=1 → in_ready all 0, out_valid=0, out_data=0. Release rst → first beat from ch0 appears at cycle +1 with out_id=0.
- Round-robin fairness: N=4, ROUND_ROBIN=1, all channels continuously valid, single-beat, out_ready=1 → out_id sequence 0,1,2,3,0,1,… at one beat/cycle.
- Fixed priority: ROUND_ROBIN=0, ch1 and ch3 continuously valid → out_id always 1. Drop ch1 → out_id=3 on the next beat.
- Packet lock: ch2 sends 3 beats, last on the 3rd, with ch0 valid throughout and a 1-cycle in_valid gap on ch2 mid-packet → out_id = 2,2,2, a bubble of no ch0 grant during the gap, then 0. After that, ptr=3.
- Backpressure: out_ready=0 for 5 cycles with a beat held (data 0xA5) → out_data stays 0xA5, all in_ready=0. When out_ready=1 with a waiting channel → next beat loads the same edge, no gap.
- Mid-packet reset: assert rst after the 1st beat of a 4-beat packet on ch1 → locked=0, out_valid=0. After release, ch0 is granted first if valid.
